// File: rtl/dso_cmd_proc.sv
// DSO configuration command processor: executes READ/WRITE/DUMP commands from the
// UART transceiver, maintains the four configuration registers and sends response bytes.
module dso_cmd_proc (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] cmd,
   input  logic        cmd_rdy,
   output logic        clr_cmd_rdy,
   output logic        trmt,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   output logic [7:0]  trig_lvl,
   output logic [3:0]  decimator,
   output logic [5:0]  trig_cfg,
   output logic [2:0]  ch1_gain,
   output logic [2:0]  ch2_gain
);

   localparam logic [7:0] OP_READ  = 8'h01;
   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_DUMP  = 8'h03;
   localparam logic [7:0] RSP_ACK  = 8'hA5;
   localparam logic [7:0] RSP_NAK  = 8'hEE;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXEC    = 2'd1,
      WAIT_TX = 2'd2
   } state_t;

   state_t      state_r, state_s;
   logic [7:0]  op_r, op_s;
   logic [1:0]  idx_r, idx_s;
   logic        tx_done_r;
   logic        tx_rise_s;
   logic        addr_ok_s;
   logic        clr_s, trmt_s;
   logic [7:0]  tx_data_s;
   logic        wr_en_s;
   logic [1:0]  wr_addr_s;
   logic [7:0]  wr_data_s;

   // Read-back view of a register: implemented fields packed, unimplemented bits zero
   function automatic logic [7:0] reg_read(input logic [1:0] addr, input logic [7:0] r0,
                                           input logic [3:0] r1, input logic [5:0] r2,
                                           input logic [2:0] g1, input logic [2:0] g2);
      case (addr)
         2'd0:    reg_read = r0;
         2'd1:    reg_read = {4'h0, r1};
         2'd2:    reg_read = {2'b00, r2};
         default: reg_read = {1'b0, g2, 1'b0, g1};
      endcase
   endfunction

   assign tx_rise_s = tx_done & ~tx_done_r;
   assign addr_ok_s = (cmd[15:8] < 8'd4);

   // Next-state and next-output logic; EXEC actions are computed on the way into EXEC
   always_comb begin
      state_s   = state_r;
      op_s      = op_r;
      idx_s     = idx_r;
      clr_s     = 1'b0;
      trmt_s    = 1'b0;
      tx_data_s = tx_data;
      wr_en_s   = 1'b0;
      wr_addr_s = cmd[9:8];
      wr_data_s = cmd[7:0];
      case (state_r)
         IDLE: begin
            if (cmd_rdy) begin
               state_s = EXEC;
               op_s    = cmd[23:16];
               idx_s   = 2'd0;
               clr_s   = 1'b1;
               trmt_s  = 1'b1;
               case (cmd[23:16])
                  OP_READ: begin
                     if (addr_ok_s) begin
                        tx_data_s = reg_read(cmd[9:8], trig_lvl, decimator, trig_cfg,
                                             ch1_gain, ch2_gain);
                     end else begin
                        tx_data_s = RSP_NAK;
                     end
                  end
                  OP_WRITE: begin
                     if (addr_ok_s) begin
                        wr_en_s   = 1'b1;
                        tx_data_s = RSP_ACK;
                     end else begin
                        tx_data_s = RSP_NAK;
                     end
                  end
                  OP_DUMP: tx_data_s = reg_read(2'd0, trig_lvl, decimator, trig_cfg,
                                                ch1_gain, ch2_gain);
                  default: tx_data_s = RSP_NAK;
               endcase
            end else begin
               state_s = IDLE;
            end
         end
         EXEC: state_s = WAIT_TX;
         WAIT_TX: begin
            if (tx_rise_s) begin
               if ((op_r == OP_DUMP) && (idx_r < 2'd3)) begin
                  idx_s     = idx_r + 2'd1;
                  trmt_s    = 1'b1;
                  tx_data_s = reg_read(idx_r + 2'd1, trig_lvl, decimator, trig_cfg,
                                       ch1_gain, ch2_gain);
               end else begin
                  state_s = IDLE;
               end
            end else begin
               state_s = WAIT_TX;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // FSM state, command latch, tx_done history and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         op_r        <= 8'h00;
         idx_r       <= 2'd0;
         tx_done_r   <= 1'b0;
         clr_cmd_rdy <= 1'b0;
         trmt        <= 1'b0;
         tx_data     <= 8'h00;
      end else begin
         state_r     <= state_s;
         op_r        <= op_s;
         idx_r       <= idx_s;
         tx_done_r   <= tx_done;
         clr_cmd_rdy <= clr_s;
         trmt        <= trmt_s;
         tx_data     <= tx_data_s;
      end
   end

   // Configuration register file; writes truncate to the implemented fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_lvl  <= 8'h80;
         decimator <= 4'h0;
         trig_cfg  <= 6'h00;
         ch1_gain  <= 3'd2;
         ch2_gain  <= 3'd2;
      end else if (wr_en_s) begin
         case (wr_addr_s)
            2'd0:    trig_lvl  <= wr_data_s;
            2'd1:    decimator <= wr_data_s[3:0];
            2'd2:    trig_cfg  <= wr_data_s[5:0];
            default: begin
               ch1_gain <= wr_data_s[2:0];
               ch2_gain <= wr_data_s[6:4];
            end
         endcase
      end else begin
         trig_lvl <= trig_lvl;
      end
   end

endmodule
